apb_arb_master: RTL

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master_if.sv | 36 +++
 rtl/apb_arb_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/apb_arb_master_if.sv
// Bundle between apb_arb_master and its environment: two requester ports,
// the response strobes and the APB master-side signals.
interface apb_arb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;

    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin arbiter feeding a single APB master with a
// per-transfer wait-state timeout that reports an error response on abort.
module apb_arb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_arb_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_prio;
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [7:0]          r_wait;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_any;
    logic                w_gnt_idx;
    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic [1:0]          w_req_ready;
    logic [7:0]          w_wait_inc;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_write;

    // r_prio names the requester that wins a tie; it flips away from every grant.
    always_comb begin
        w_any     = |bus.req_valid;
        w_gnt_idx = 1'b0;
        if (bus.req_valid == 2'b11) begin
            w_gnt_idx = r_prio;
        end else begin
            w_gnt_idx = bus.req_valid[1];
        end
        w_sel_addr  = w_gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
        w_sel_wdata = w_gnt_idx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
        w_sel_write = w_gnt_idx ? bus.req_write[1]                 : bus.req_write[0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_req_ready = 2'b00;
        w_wait_inc  = r_wait + 8'd1;
        case (r_state)
            S_IDLE: begin
                if (w_any && PRESETn) begin
                    w_accept    = 1'b1;
                    w_req_ready = {w_gnt_idx, ~w_gnt_idx};
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle.
                if (bus.PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_wait_inc == LP_TIMEOUT) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_wait      <= 8'd0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;

            if (w_accept) begin
                r_gnt    <= w_gnt_idx;
                r_prio   <= ~w_gnt_idx;
                r_paddr  <= w_sel_addr;
                r_pwdata <= w_sel_wdata;
                r_pwrite <= w_sel_write;
            end

            if (r_state == S_SETUP) begin
                r_wait <= 8'd0;
            end else if ((r_state == S_ACCESS) && !bus.PREADY) begin
                r_wait <= w_wait_inc;
            end

            if (w_done) begin
                r_rsp_valid <= {r_gnt, ~r_gnt};
                r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            end else if (w_abort) begin
                r_rsp_valid <= {r_gnt, ~r_gnt};
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSEL      = (r_state != S_IDLE);
    assign bus.PENABLE   = (r_state == S_ACCESS);
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

    a_ready_only_idle: assert property (@(posedge PCLK) disable iff (!PRESETn)
        (bus.req_ready == 2'b00) || (r_state == S_IDLE));
    a_rsp_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn)
        $onehot0(bus.rsp_valid));
    a_enable_needs_sel: assert property (@(posedge PCLK) disable iff (!PRESETn)
        !bus.PENABLE || bus.PSEL);
endmodule
